cache_sa_wb: RTL

- Parametrised N-way set-associative, write-back, write-allocate cache between the CPU data port and the 128-bit external memory port.
- Successor to the direct-mapped write-through data cache: adds configurable ways and depth, dirty-line writeback, and LRU replacement.
- Keeps the same CPU and memory handshake signal set, so it drops into the existing memory arbiter slot.

---
 rtl/cache_pkg.sv | 37 +++
 rtl/cache_way_array.sv | 89 ++++++++
 rtl/cache_sa_wb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative write-back data cache.
// Holds the controller state encoding, the fixed address-split widths,
// the derived widths at the default geometry (64 lines, 2 ways) and a helper
// that widens a byte-write mask into a bit mask for store merging.
package cache_pkg;

  // Word offset inside a 512-bit line: [3:2] selects the 128-bit beat,
  // [1:0] selects the 32-bit word inside that beat.
  localparam int OFFSET_BITS   = 4;
  localparam int BEAT_BITS     = 2;
  localparam int WORD_SEL_BITS = 2;

  // Derived widths at the default geometry (SETS = 32, 30-bit word address).
  // The top recomputes these from its own parameters.
  localparam int SET_BITS = 5;
  localparam int TAG_BITS = 21;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WB_CMD    = 3'd2,
    ST_WB_DATA   = 3'd3,
    ST_RF_CMD    = 3'd4,
    ST_RF_WAIT   = 3'd5,
    ST_FILL_DONE = 3'd6
  } state_e;

  // Expand a 4-bit byte-write enable into a 32-bit bit mask.
  function automatic logic [31:0] byte_to_bit_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: tag/valid/dirty registers per set and a data array
// of SETS x LINE_BEATS beats.
// Ports:
//   clk, reset_n     clock, asynchronous active-low clear of valid/dirty/tag
//   rd_en, rd_set    synchronous read of a whole line into line_o
//   set_i            set addressed by metadata reads/writes and beat writes
//   meta_wr_en       install meta_tag_i as valid and clean in set_i
//   dirty_set        mark set_i dirty
//   wr_en, wr_beat,  write one beat of set_i with per-byte enables wr_be
//   wr_data, wr_be
//   tag_o, valid_o,  metadata of set_i (combinational)
//   dirty_o
//   line_o           line captured by the last rd_en
module cache_way_array
  import cache_pkg::*;
#(
  parameter int SETS          = 32,
  parameter int LINE_BEATS    = 4,
  parameter int MEM_DATA_BITS = 128,
  parameter int TAG_W         = 21,
  parameter int SET_W         = 5,
  parameter int BEAT_W        = BEAT_BITS
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                rd_en,
  input  logic [SET_W-1:0]                    rd_set,
  input  logic [SET_W-1:0]                    set_i,
  input  logic                                meta_wr_en,
  input  logic [TAG_W-1:0]                    meta_tag_i,
  input  logic                                dirty_set,
  input  logic                                wr_en,
  input  logic [BEAT_W-1:0]                   wr_beat,
  input  logic [MEM_DATA_BITS-1:0]            wr_data,
  input  logic [MEM_DATA_BITS/8-1:0]          wr_be,
  output logic [TAG_W-1:0]                    tag_o,
  output logic                                valid_o,
  output logic                                dirty_o,
  output logic [LINE_BEATS*MEM_DATA_BITS-1:0] line_o
);

  localparam int NBYTES = MEM_DATA_BITS / 8;

  logic [TAG_W-1:0]                    tag_q [SETS];
  logic [SETS-1:0]                     valid_q;
  logic [SETS-1:0]                     dirty_q;
  logic [MEM_DATA_BITS-1:0]            data_mem [SETS][LINE_BEATS];
  logic [LINE_BEATS*MEM_DATA_BITS-1:0] line_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      if (meta_wr_en) begin
        tag_q[set_i]   <= meta_tag_i;
        valid_q[set_i] <= 1'b1;
        dirty_q[set_i] <= 1'b0;
      end else if (dirty_set) begin
        dirty_q[set_i] <= 1'b1;
      end
    end
  end

  // Data storage is not cleared: contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) begin
          data_mem[set_i][wr_beat][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      for (int k = 0; k < LINE_BEATS; k++) begin
        line_q[k*MEM_DATA_BITS +: MEM_DATA_BITS] <= data_mem[rd_set][k];
      end
    end
  end

  assign tag_o   = tag_q[set_i];
  assign valid_o = valid_q[set_i];
  assign dirty_o = dirty_q[set_i];
  assign line_o  = line_q;

endmodule

// File: rtl/cache_sa_wb.sv
// N-way (1 or 2) set-associative, write-back, write-allocate data cache
// between the CPU data port and the 128-bit memory port.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_req_*                    CPU request (write = byte enables, 0 = load)
//   cpu_resp_valid/data          one-cycle load response pulse
//   mem_req_valid/ready/addr/rw  memory command, addr = {tag, set, beat}
//   mem_req_data_*               writeback beat, accepted on data_ready
//   mem_resp_valid/data          refill beat, consumed only while waiting
//   dbg_state                    current controller state (cache_pkg::state_e)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn and the command/data payload is held
// stable until accepted. cpu_req_ready is high only in IDLE.
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WAYS           = 2,
  parameter int CPU_WIDTH      = 32,
  parameter int WORD_ADDR_BITS = 30,
  parameter int MEM_DATA_BITS  = 128,
  parameter int LINE_BEATS     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_req_valid,
  output logic                         cpu_req_ready,
  input  logic [WORD_ADDR_BITS-1:0]    cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]         cpu_req_data,
  input  logic [3:0]                   cpu_req_write,
  output logic                         cpu_resp_valid,
  output logic [CPU_WIDTH-1:0]         cpu_resp_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [WORD_ADDR_BITS-3:0]    mem_req_addr,
  output logic                         mem_req_rw,
  output logic                         mem_req_data_valid,
  input  logic                         mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]     mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                         mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]     mem_resp_data,
  output logic [2:0]                   dbg_state
);

  localparam int SETS   = LINES / WAYS;
  localparam int SET_W  = $clog2(SETS);
  localparam int TAG_W  = WORD_ADDR_BITS - OFFSET_BITS - SET_W;
  localparam int LINE_W = LINE_BEATS * MEM_DATA_BITS;
  localparam int NBYTES = MEM_DATA_BITS / 8;

  state_e                      state_q, state_d;
  logic [WORD_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [CPU_WIDTH-1:0]        data_q, data_d;
  logic [3:0]                  wstrb_q, wstrb_d;
  logic                        victim_q, victim_d;
  logic [BEAT_BITS-1:0]        beat_q, beat_d;
  logic                        ready_q, ready_d;

  logic [SET_W-1:0]            req_set, in_set, rd_set;
  logic [TAG_W-1:0]            req_tag;
  logic [BEAT_BITS-1:0]        req_beat;
  logic [WORD_SEL_BITS-1:0]    req_word;

  logic [TAG_W-1:0]            way_tag  [WAYS];
  logic [LINE_W-1:0]           way_line [WAYS];
  logic [WAYS-1:0]             way_valid, way_dirty;
  logic [WAYS-1:0]             wr_en_w, meta_wr_w, dirty_set_w;

  logic                        rd_en;
  logic [BEAT_BITS-1:0]        wr_beat;
  logic [MEM_DATA_BITS-1:0]    wr_data;
  logic                        hit, hit_way, vic;
  logic                        lru_way, lru_upd, lru_new;
  logic [LINE_W-1:0]           hit_line, vic_line;
  logic [MEM_DATA_BITS-1:0]    merged_beat;
  logic [CPU_WIDTH-1:0]        old_word, hit_word, store_mask;

  assign req_set  = addr_q[OFFSET_BITS +: SET_W];
  assign req_tag  = addr_q[WORD_ADDR_BITS-1 -: TAG_W];
  assign req_beat = addr_q[3:2];
  assign req_word = addr_q[1:0];
  assign in_set   = cpu_req_addr[OFFSET_BITS +: SET_W];

  assign cpu_req_ready = ready_q;
  assign dbg_state     = state_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_array #(
      .SETS          (SETS),
      .LINE_BEATS    (LINE_BEATS),
      .MEM_DATA_BITS (MEM_DATA_BITS),
      .TAG_W         (TAG_W),
      .SET_W         (SET_W),
      .BEAT_W        (BEAT_BITS)
    ) u_way (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_en      (rd_en),
      .rd_set     (rd_set),
      .set_i      (req_set),
      .meta_wr_en (meta_wr_w[w]),
      .meta_tag_i (req_tag),
      .dirty_set  (dirty_set_w[w]),
      .wr_en      (wr_en_w[w]),
      .wr_beat    (wr_beat),
      .wr_data    (wr_data),
      .wr_be      ({NBYTES{1'b1}}),
      .tag_o      (way_tag[w]),
      .valid_o    (way_valid[w]),
      .dirty_o    (way_dirty[w]),
      .line_o     (way_line[w])
    );
  end

  // One LRU bit per set naming the way to evict next.
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lru_q <= '0;
      end else if (lru_upd) begin
        lru_q[req_set] <= lru_new;
      end
    end
    assign lru_way = lru_q[req_set];
  end else begin : g_no_lru
    assign lru_way = 1'b0;
  end

  // Hit detection, victim choice and store merge against the set read at
  // acceptance (or re-read after a fill).
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
    if (!way_valid[0]) begin
      vic = 1'b0;
    end else if ((WAYS == 2) && !way_valid[WAYS-1]) begin
      vic = 1'b1;
    end else begin
      vic = lru_way;
    end
    hit_line    = way_line[hit_way];
    vic_line    = way_line[victim_q];
    hit_word    = hit_line[int'(addr_q[3:0])*CPU_WIDTH +: CPU_WIDTH];
    merged_beat = hit_line[int'(req_beat)*MEM_DATA_BITS +: MEM_DATA_BITS];
    old_word    = merged_beat[int'(req_word)*CPU_WIDTH +: CPU_WIDTH];
    store_mask  = byte_to_bit_mask(wstrb_q);
    merged_beat[int'(req_word)*CPU_WIDTH +: CPU_WIDTH] =
      (old_word & ~store_mask) | (data_q & store_mask);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wstrb_d  = wstrb_q;
    victim_d = victim_q;
    beat_d   = beat_q;

    rd_en       = 1'b0;
    rd_set      = in_set;
    wr_en_w     = '0;
    meta_wr_w   = '0;
    dirty_set_w = '0;
    wr_beat     = beat_q;
    wr_data     = mem_resp_data;
    lru_upd     = 1'b0;
    lru_new     = 1'b0;

    cpu_resp_valid     = 1'b0;
    cpu_resp_data      = '0;
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;

    case (state_q)
      ST_IDLE: begin
        if (ready_q && cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          data_d  = cpu_req_data;
          wstrb_d = cpu_req_write;
          rd_en   = 1'b1;
          rd_set  = in_set;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          lru_upd = 1'b1;
          lru_new = ~hit_way;
          if (wstrb_q == 4'd0) begin
            cpu_resp_valid = 1'b1;
            cpu_resp_data  = hit_word;
          end else begin
            wr_en_w[hit_way]     = 1'b1;
            dirty_set_w[hit_way] = 1'b1;
            wr_beat              = req_beat;
            wr_data              = merged_beat;
          end
          state_d = ST_IDLE;
        end else begin
          victim_d = vic;
          beat_d   = '0;
          state_d  = (way_valid[vic] && way_dirty[vic]) ? ST_WB_CMD : ST_RF_CMD;
        end
      end
      ST_WB_CMD: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {way_tag[victim_q], req_set, beat_q};
        if (mem_req_ready) state_d = ST_WB_DATA;
      end
      ST_WB_DATA: begin
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = vic_line[int'(beat_q)*MEM_DATA_BITS +: MEM_DATA_BITS];
        mem_req_data_mask  = '1;
        if (mem_req_data_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_BITS'(LINE_BEATS-1)) begin
            beat_d  = '0;
            state_d = ST_RF_CMD;
          end else begin
            state_d = ST_WB_CMD;
          end
        end
      end
      ST_RF_CMD: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = {req_tag, req_set, beat_q};
        if (mem_req_ready) state_d = ST_RF_WAIT;
      end
      ST_RF_WAIT: begin
        if (mem_resp_valid) begin
          wr_en_w[victim_q] = 1'b1;
          wr_beat           = beat_q;
          wr_data           = mem_resp_data;
          beat_d            = beat_q + 1'b1;
          if (beat_q == BEAT_BITS'(LINE_BEATS-1)) begin
            beat_d  = '0;
            state_d = ST_FILL_DONE;
          end else begin
            state_d = ST_RF_CMD;
          end
        end
      end
      ST_FILL_DONE: begin
        // Install the tag and re-read the set so the replayed lookup hits.
        meta_wr_w[victim_q] = 1'b1;
        rd_en               = 1'b1;
        rd_set              = req_set;
        state_d             = ST_LOOKUP;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered so it is low while reset is held and never glitches.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      wstrb_q  <= '0;
      victim_q <= 1'b0;
      beat_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wstrb_q  <= wstrb_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      ready_q  <= ready_d;
    end
  end

endmodule
